// File: rtl/instr_decode_pkg.sv
// Shared pipeline types for the fetch->decode->execute boundary.
// Holds the stage-register structs, ALU/writeback encodings and RV32I opcode constants.
package pipeline_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_t;
  typedef enum logic [1:0] { SRCA_RS1, SRCA_PC, SRCA_ZERO } src_a_t;
  typedef enum logic       { SRCB_RS2, SRCB_IMM } src_b_t;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    src_a_t      alu_srcA;
    src_b_t      alu_srcB;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    wb_sel_t     wb_sel;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
    logic        valid;
  } id_ex_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Register-file access bus between the decoder (master) and reg_file (slave).
interface instr_decode_if;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  modport master (output rs1, rs2, wbEn, wbRd, wbData, input rs1Data, rs2Data);
  modport slave  (input rs1, rs2, wbEn, wbRd, wbData, output rs1Data, rs2Data);
endinterface

// File: rtl/instr_decode_reg_file.sv
// 32x32 register file, two combinational read ports, one write port.
// Reads forward a same-cycle writeback so decode sees the newest value.
module reg_file (
  input  logic iClk,
  input  logic iRst,
  instr_decode_if.slave rf
);
  logic [31:0] regs [32];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf.wbEn && rf.wbRd != 5'd0) begin
      regs[rf.wbRd] <= rf.wbData;
    end
  end

  always_comb begin
    rf.rs1Data = '0;
    rf.rs2Data = '0;
    if (rf.rs1 != 5'd0) rf.rs1Data = (rf.wbEn && rf.wbRd == rf.rs1) ? rf.wbData : regs[rf.rs1];
    if (rf.rs2 != 5'd0) rf.rs2Data = (rf.wbEn && rf.wbRd == rf.rs2) ? rf.wbData : regs[rf.rs2];
  end
endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: immediate/control decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module instr_decode
  import pipeline_types::*;
(
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic        iFlush,
  input  logic        iStall,
  input  if_id_t      iID,
  input  logic        iWB_en,
  input  logic [4:0]  iWB_rd,
  input  logic [31:0] iWB_data,
  input  logic        iEX_memRd,
  input  logic [4:0]  iEX_rd,
  output logic        oStall,
  output id_ex_t      oEX
);
  instr_decode_if rf ();

  reg_file u_rf (.iClk(iClk), .iRst(iRst), .rf(rf));

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic        use1, use2, legal;
  logic [4:0]  rs1Idx, rs2Idx;
  id_ex_t      dec, nextEx;

  assign ins = iID.instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  assign immI = {{20{ins[31]}}, ins[31:20]};
  assign immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign immU = {ins[31:12], 12'b0};
  assign immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    use1       = 1'b0;
    use2       = 1'b0;
    legal      = 1'b1;
    dec.pc     = iID.pc;
    dec.pc4    = iID.pc4;
    dec.funct3 = f3;
    dec.valid  = 1'b1;
    case (opc)
      OPC_LUI: begin
        dec.imm = immU; dec.alu_srcA = SRCA_ZERO; dec.alu_srcB = SRCB_IMM; dec.reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = immU; dec.alu_srcA = SRCA_PC; dec.alu_srcB = SRCB_IMM; dec.reg_wr = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = immJ; dec.alu_srcA = SRCA_PC; dec.alu_srcB = SRCB_IMM;
        dec.reg_wr = 1'b1; dec.wb_sel = WB_PC4; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = immI; dec.alu_srcB = SRCB_IMM; use1 = 1'b1;
        dec.reg_wr = 1'b1; dec.wb_sel = WB_PC4; dec.jump = 1'b1; dec.jalr = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm = immB; dec.alu_op = ALU_SUB; dec.branch = 1'b1; use1 = 1'b1; use2 = 1'b1;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_LOAD: begin
        dec.imm = immI; dec.alu_srcB = SRCB_IMM; use1 = 1'b1;
        dec.mem_rd = 1'b1; dec.reg_wr = 1'b1; dec.wb_sel = WB_MEM;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        dec.imm = immS; dec.alu_srcB = SRCB_IMM; dec.mem_wr = 1'b1; use1 = 1'b1; use2 = 1'b1;
        legal = (f3 < 3'd3);
      end
      OPC_OPIMM: begin
        dec.imm = immI; dec.alu_srcB = SRCB_IMM; dec.reg_wr = 1'b1; use1 = 1'b1;
        dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && ins[30]);
        // Only the shift forms constrain funct7; it is immediate data otherwise.
        if (f3 == 3'b001) legal = (f7 == 7'b0000000);
        if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      OPC_OP: begin
        dec.reg_wr = 1'b1; use1 = 1'b1; use2 = 1'b1;
        dec.alu_op = alu_from_f3(f3, ins[30]);
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: legal = 1'b0;
    endcase

    if (ins == 32'h0) begin
      dec  = '0;
      use1 = 1'b0;
      use2 = 1'b0;
    end else if (!legal) begin
      dec         = '0;
      dec.pc      = iID.pc;
      dec.pc4     = iID.pc4;
      dec.illegal = 1'b1;
      dec.valid   = 1'b1;
      use1        = 1'b0;
      use2        = 1'b0;
    end else begin
      dec.rd = dec.reg_wr ? ins[11:7] : 5'd0;
    end

    // Unused source indices collapse to x0 so they can never raise a hazard.
    rs1Idx  = use1 ? ins[19:15] : 5'd0;
    rs2Idx  = use2 ? ins[24:20] : 5'd0;
    dec.rs1 = rs1Idx;
    dec.rs2 = rs2Idx;
  end

  assign rf.rs1    = rs1Idx;
  assign rf.rs2    = rs2Idx;
  assign rf.wbEn   = iWB_en;
  assign rf.wbRd   = iWB_rd;
  assign rf.wbData = iWB_data;

  always_comb begin
    nextEx          = dec;
    nextEx.rs1_data = rf.rs1Data;
    nextEx.rs2_data = rf.rs2Data;
  end

  assign oStall = ~iRst & iEX_memRd & (iEX_rd != 5'd0) &
                  ((rs1Idx == iEX_rd) | (rs2Idx == iEX_rd));

  always_ff @(posedge iClk) begin
    if (iRst)                oEX <= '0;
    else if (iFlush)         oEX <= '0;
    else if (!iStall && iEn) oEX <= oStall ? id_ex_t'('0) : nextEx;
  end
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have ports: iClk in 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port iRst in 1; reset is synchronous and active-high.
REQ-003 SHALL have port iEn in 1: stage enable; when low, oEX holds and register-file writes still occur.
REQ-004 SHALL have port iFlush in 1: replace the next oEX with a bubble.
REQ-005 SHALL have port iStall in 1: downstream stall; hold oEX.
REQ-006 SHALL have port iID in if_id_t: pc, pc4, instruction from fetch.
REQ-007 SHALL have ports iWB_en in 1, iWB_rd in 5, iWB_data in 32: register-file write port.
REQ-008 SHALL have ports iEX_memRd in 1, iEX_rd in 5: load in EX and its destination, for hazard detection.
REQ-009 SHALL have port oStall out 1: load-use stall request to fetch; combinational.
REQ-010 SHALL have port oEX out id_ex_t: pipeline register to execute.

Function
REQ-011 SHALL decode RV32I: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (as NOP), SYSTEM (as NOP).
REQ-012 SHALL generate sign-extended 32-bit immediates for I/S/B/U/J formats; B/J bit0 = 0; U low 12 bits = 0.
REQ-013 SHALL contain a 32x32 register file with combinational reads of rs1/rs2.
- x0 reads 0 and ignores writes.
- Writes happen on the rising edge when iWB_en=1 and iWB_rd!=0.
REQ-014 SHALL bypass same-cycle writeback: if iWB_en and iWB_rd==rs (rs!=0), the read returns iWB_data.
REQ-015 SHALL assert oStall when all hold:
- iEX_memRd=1 and iEX_rd!=0.
- iEX_rd equals an rs1 or rs2 actually used by the current opcode.
REQ-016 SHALL, while oStall=1 and iStall=0, load a bubble into oEX; the instruction is re-presented by the stalled fetch.
REQ-017 SHALL define a bubble as all control fields 0 (reg_wr, mem_rd, mem_wr, branch, jump, illegal, valid), with data fields 0.
REQ-018 SHALL treat instruction 32'h0 (flushed fetch) as a bubble, not illegal.
REQ-019 SHALL, for any other unsupported opcode or funct encoding, load oEX with all control fields 0 except illegal=1 and valid=1.
REQ-020 SHALL use oEX update priority: iRst > iFlush > iStall (hold) > ~iEn (hold) > load-use bubble > decoded instruction.
REQ-021 SHALL have one-cycle latency: iID sampled at edge N appears on oEX after edge N.
REQ-022 SHALL populate oEX fields:
- pc, pc4, rs1/rs2 data, imm, rs1, rs2, rd, funct3.
- alu_op, alu_srcA (rs1/pc/zero), alu_srcB (rs2/imm).
- mem_rd, mem_wr, reg_wr, wb_sel (alu/mem/pc4), branch, jump, jalr, illegal, valid.
REQ-023 SHALL force rd=0 and reg_wr=0 for STORE, BRANCH, FENCE, SYSTEM.

Reset
REQ-024 SHALL, on iRst=1 at an edge, set oEX to a bubble with pc=pc4=0.
REQ-025 SHALL clear all 32 registers on reset.
REQ-026 SHALL ignore a writeback presented in the reset cycle.
REQ-027 SHALL keep oStall combinational and hold it at 0 while iRst=1.

Structure
REQ-028 SHALL define id_ex_t, alu_op_t, wb_sel_t and the opcode constants in pipeline_types next to if_id_t.
REQ-029 SHALL place the register file in sub-module reg_file (2R1W, with bypass).
REQ-030 SHALL keep immediate generation and control decode as combinational logic inside instr_decode.

Verification
REQ-031 SHALL cover: write x5=32'hDEADBEEF, then ADDI x6,x5,1 -> oEX.rs1_data=32'hDEADBEEF, imm=1, reg_wr=1, rd=6.
REQ-032 SHALL cover: writeback x7=32'h12345678 in the same cycle as ADD x8,x7,x0 -> rs1_data=32'h12345678 via bypass.
REQ-033 SHALL cover: iEX_memRd=1, iEX_rd=5, ADD x1,x5,x2 -> oStall=1, next oEX is a bubble; with iEX_rd=0 -> oStall=0.
REQ-034 SHALL cover: BEQ with imm -4096 -> oEX.imm=32'hFFFFF000, branch=1, reg_wr=0, rd=0.
REQ-035 SHALL cover: iFlush and iStall asserted together -> bubble; iStall alone -> oEX unchanged for 3 cycles.
REQ-036 SHALL cover: opcode 7'b1111111 -> illegal=1, valid=1; instruction 0 -> bubble; iRst mid-stream -> bubble and x1..x31 read 0.
